// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the arithmetic practical set
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } div_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of a down-counter that holds WIDTH-1 .. 0.
  function automatic int count_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/trial_subtractor.sv
// rtl/trial_subtractor.sv - combinational WIDTH-bit trial subtract returning T and its sign bit
module trial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-2:0] diff,
  output logic             borrow
);

  logic [WIDTH-1:0] t;

  assign t      = minuend - subtrahend;
  assign diff   = t[WIDTH-2:0];
  assign borrow = t[WIDTH-1];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] next_r;
  logic [WIDTH-1:0] next_q;

  // R only ever holds a value below D, so its top bit is always zero and is
  // supplied as the leading 0 of S rather than stored.
  assign s = {r, q[WIDTH-1]};

  trial_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_trial_subtractor (
    .minuend   (s),
    .subtrahend({1'b0, d}),
    .diff      (diff),
    .borrow    (borrow)
  );

  assign next_r = borrow ? s[WIDTH-1:0] : diff;
  assign next_q = {q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= ST_DONE;
              ready       <= 1'b1;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              ready <= 1'b0;
              r     <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= CW'(WIDTH - 1);
            end
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r     <= next_r;
          q     <= next_q;
          count <= count - 1'b1;
          if (count == '0) begin
            state       <= ST_DONE;
            ready       <= 1'b1;
            done        <= 1'b1;
            quotient    <= next_q;
            remainder   <= next_r;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and sweep bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called away from the clock edge; returns #1 after the edge that opened the
  // DONE cycle, so a following call naturally starts back-to-back.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int eq, input int er, input int ez, input int edges,
                         input bit meddle);
    int k;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 12) begin
      check({tag, "_ready_run"}, ready, 0);
      if (meddle) begin
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_edges"}, k, edges);
    check({tag, "_ready_done"}, ready, 1);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, done, 0);
    check({tag, "_ready_idle"}, ready, 1);
  endtask

  initial begin
    bit saw_done;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle("post_rst");

    run_div("d7_2", 4'd7, 4'd2, 3, 1, 0, 4, 1'b0);
    idle_cycle("d7_2");

    run_div("d15_1", 4'd15, 4'd1, 15, 0, 0, 4, 1'b0);
    run_div("d3_5_b2b", 4'd3, 4'd5, 0, 3, 0, 4, 1'b0);
    idle_cycle("d3_5");

    run_div("d9_0", 4'd9, 4'd0, 15, 9, 1, 0, 1'b0);
    idle_cycle("d9_0");
    run_div("d8_3", 4'd8, 4'd3, 2, 2, 0, 4, 1'b0);
    idle_cycle("d8_3");

    run_div("d13_4_meddle", 4'd13, 4'd4, 3, 1, 0, 4, 1'b1);
    idle_cycle("d13_4");

    // Asynchronous reset two edges into a 14/3 division.
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_quot", quotient, 0);
    check("arst_rem", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    check("arst_ready", ready, 1);
    check("arst_done", done, 0);
    #2;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", saw_done, 0);
    check("arst_quot_held", quotient, 0);
    run_div("d14_3", 4'd14, 4'd3, 4, 2, 0, 4, 1'b0);
    idle_cycle("d14_3");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_div($sformatf("sw%0d_%0d", a, b), W'(a), W'(b), 15, a, 1, 0, 1'b0);
        else
          run_div($sformatf("sw%0d_%0d", a, b), W'(a), W'(b), a / b, a % b, 0, 4, 1'b0);
      end
    end
    idle_cycle("sweep_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
